// File: rtl/vending_if.sv
// -----------------------------------------------------------------------------
// vending_if
// Signal bundle between the coin/cancel front end and the vending controller.
//   master : drives coin_in / cancel, observes the controller outputs
//   slave  : the vending controller itself
// Signals:
//   coin_in[N_COIN]  single-cycle debounced coin pulses, one bit per channel
//   cancel           single-cycle refund request
//   credit           credit currently held (units of 0.5 yuan)
//   led[LED_W]       thermometer display of credit
//   dispense         one-cycle item release pulse
//   refund           one-cycle cancel/timeout refund pulse
//   change_vld       one-cycle pulse qualifying change
//   change           amount to return, zero outside change_vld
//   coin_rej         one-cycle pulse: a coin arrived while it could not be taken
//   busy             controller is not idle
// The parameters must match those of the vending_fsm instance it connects to.
// -----------------------------------------------------------------------------
interface vending_if #(
  parameter int CREDIT_W = 4,
  parameter int N_COIN   = 2,
  parameter int LED_W    = 8
);
  logic [N_COIN-1:0]   coin_in;
  logic                cancel;
  logic [CREDIT_W-1:0] credit;
  logic [LED_W-1:0]    led;
  logic                dispense;
  logic                refund;
  logic                change_vld;
  logic [CREDIT_W-1:0] change;
  logic                coin_rej;
  logic                busy;

  modport master (
    output coin_in, cancel,
    input  credit, led, dispense, refund, change_vld, change, coin_rej, busy
  );

  modport slave (
    input  coin_in, cancel,
    output credit, led, dispense, refund, change_vld, change, coin_rej, busy
  );
endinterface

// File: rtl/vending_fsm.sv
// -----------------------------------------------------------------------------
// vending_fsm
// Parametrised coin-operated vending controller. Accumulates credit from
// N_COIN coin channels, dispenses once credit reaches PRICE and returns the
// exact change, refunds on cancel or after TIMEOUT_CYCLES of inactivity, and
// drives a thermometer LED bank of the current credit. All outputs are
// registered.
// Ports:
//   clk  single clock
//   rst  synchronous active-high reset
//   bus  vending_if slave modport (coin/cancel in, credit/led/pulses out)
// -----------------------------------------------------------------------------
module vending_fsm #(
  parameter int                           CREDIT_W       = 4,
  parameter int                           N_COIN         = 2,
  parameter logic [N_COIN*CREDIT_W-1:0]   COIN_VAL       = {4'd2, 4'd1},
  parameter int                           PRICE          = 6,
  parameter int                           TIMEOUT_CYCLES = 250_000_000,
  parameter int                           LED_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  vending_if.slave   bus
);

  function automatic int coin_total();
    int s = 0;
    for (int i = 0; i < N_COIN; i++) s += int'(COIN_VAL[i*CREDIT_W +: CREDIT_W]);
    return s;
  endfunction

  localparam int COIN_TOTAL = coin_total();

  // Worst case credit is PRICE-1 plus every channel at once; that must fit
  // in CREDIT_W bits so change never needs the carry bit.
  if (PRICE < 1 || TIMEOUT_CYCLES < 2 ||
      PRICE - 1 + COIN_TOTAL >= 2**CREDIT_W) begin : g_cfg_err
    $error("vending_fsm: illegal PRICE/COIN_VAL/TIMEOUT_CYCLES configuration");
  end

  localparam int                  CNT_W      = $clog2(TIMEOUT_CYCLES);
  localparam int                  CNT_LAST_I = TIMEOUT_CYCLES - 2;
  // The refund decision is made one cycle before the registered refund pulse
  // appears, so the last counted value is TIMEOUT_CYCLES-2.
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_LAST_I[CNT_W-1:0];
  localparam logic [CREDIT_W:0]   PRICE_X    = PRICE[CREDIT_W:0];
  localparam logic [CREDIT_W-1:0] PRICE_N    = PRICE[CREDIT_W-1:0];

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_VEND, ST_REFUND} state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CREDIT_W-1:0] chg_d;

  logic [CREDIT_W:0]   sum, nxt;
  logic                has_coin, paid;

  logic [LED_W-1:0]    led_q, led_d;
  logic                dispense_q, dispense_d;
  logic                refund_q, refund_d;
  logic                change_vld_q, change_vld_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                coin_rej_q, coin_rej_d;
  logic                busy_q, busy_d;

  // State and output registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= ST_IDLE;
      credit_q     <= '0;
      cnt_q        <= '0;
      led_q        <= '0;
      dispense_q   <= 1'b0;
      refund_q     <= 1'b0;
      change_vld_q <= 1'b0;
      change_q     <= '0;
      coin_rej_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      cnt_q        <= cnt_d;
      led_q        <= led_d;
      dispense_q   <= dispense_d;
      refund_q     <= refund_d;
      change_vld_q <= change_vld_d;
      change_q     <= change_d;
      coin_rej_q   <= coin_rej_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic: credit, timeout counter and change to be presented.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would infer a latch.
    sum = '0;
    for (int i = 0; i < N_COIN; i++) begin
      if (bus.coin_in[i]) sum = sum + {1'b0, COIN_VAL[i*CREDIT_W +: CREDIT_W]};
    end
    nxt      = {1'b0, credit_q} + sum;
    has_coin = (sum != '0);
    paid     = (nxt >= PRICE_X);

    state_d  = state_q;
    credit_d = credit_q;
    cnt_d    = cnt_q;
    chg_d    = '0;

    case (state_q)
      ST_IDLE: begin
        credit_d = '0;
        cnt_d    = '0;
        if (has_coin) begin
          if (paid) begin
            state_d = ST_VEND;
            chg_d   = nxt[CREDIT_W-1:0] - PRICE_N;
          end else begin
            state_d  = ST_COLLECT;
            credit_d = nxt[CREDIT_W-1:0];
          end
        end
      end

      ST_COLLECT: begin
        if (has_coin) begin
          // The coin is counted first; a completed purchase overrides cancel.
          cnt_d = '0;
          if (paid) begin
            state_d  = ST_VEND;
            credit_d = '0;
            chg_d    = nxt[CREDIT_W-1:0] - PRICE_N;
          end else if (bus.cancel) begin
            state_d  = ST_REFUND;
            credit_d = '0;
            chg_d    = nxt[CREDIT_W-1:0];
          end else begin
            credit_d = nxt[CREDIT_W-1:0];
          end
        end else if (bus.cancel || cnt_q == CNT_LAST) begin
          state_d  = ST_REFUND;
          credit_d = '0;
          cnt_d    = '0;
          chg_d    = credit_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_VEND, ST_REFUND: begin
        state_d  = ST_IDLE;
        credit_d = '0;
        cnt_d    = '0;
      end

      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  // Output logic: values the output registers take on the coming edge.
  always_comb begin
    dispense_d   = (state_d == ST_VEND);
    refund_d     = (state_d == ST_REFUND);
    change_vld_d = dispense_d | refund_d;
    change_d     = chg_d;
    busy_d       = (state_d != ST_IDLE);
    coin_rej_d   = (state_q == ST_VEND || state_q == ST_REFUND) && (|bus.coin_in);
    led_d        = '0;
    for (int k = 0; k < LED_W; k++) led_d[k] = (int'(credit_d) > k);
  end

  assign bus.credit     = credit_q;
  assign bus.led        = led_q;
  assign bus.dispense   = dispense_q;
  assign bus.refund     = refund_q;
  assign bus.change_vld = change_vld_q;
  assign bus.change     = change_q;
  assign bus.coin_rej   = coin_rej_q;
  assign bus.busy       = busy_q;

endmodule
